// File: rtl/pulse_stretch_pkg.sv
// -----------------------------------------------------------------------------
// pulse_stretch_pkg
//
// Shared definitions for the multi-channel pulse stretcher:
//   - ch_state_t      : per-channel IDLE/ACTIVE state encoding
//   - CH_DEFAULT      : default number of channels
//   - CNT_W_DEFAULT   : default width of the length input and channel counters
//   - LEN_DEF_DEFAULT : default pulse length applied when len is 0
// -----------------------------------------------------------------------------
package pulse_stretch_pkg;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } ch_state_t;

    localparam int CH_DEFAULT      = 4;
    localparam int CNT_W_DEFAULT   = 5;
    localparam int LEN_DEF_DEFAULT = 10;

endpackage : pulse_stretch_pkg

// File: rtl/pulse_stretch_ch.sv
// -----------------------------------------------------------------------------
// pulse_stretch_ch
//
// One pulse-stretch channel: an IDLE/ACTIVE machine with a down-counter.
// A trigger in IDLE loads cnt with eff_len-1 and raises dout from the next
// cycle, so a single-cycle trigger yields exactly eff_len high cycles.
// eff_len is len sampled at the trigger edge, or LEN_DEF when len is 0.
//
// Optional feature (macro PULSE_STRETCH_DONE_EN): adds output done, a
// one-cycle pulse in the first cycle dout is low after a pulse ends.
//
// Ports:
//   clk        in   rising-edge clock
//   rstn       in   asynchronous active-low reset
//   en         in   trigger, level-sampled every edge
//   len        in   pulse length in cycles (0 selects LEN_DEF)
//   retrig     in   1 = retriggerable, 0 = one-shot
//   dout       out  registered stretched pulse
//   active_nxt out  next-state ACTIVE flag, used by the top to register busy
//   done       out  end-of-pulse strobe (PULSE_STRETCH_DONE_EN only)
// -----------------------------------------------------------------------------
module pulse_stretch_ch
    import pulse_stretch_pkg::*;
#(
    parameter int CNT_W   = CNT_W_DEFAULT,
    parameter int LEN_DEF = LEN_DEF_DEFAULT   // must be at least 1
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             en,
    input  logic [CNT_W-1:0] len,
    input  logic             retrig,
    output logic             dout,
    output logic             active_nxt
`ifdef PULSE_STRETCH_DONE_EN
    ,
    output logic             done
`endif
);

    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] DEF_LOAD = CNT_W'(LEN_DEF - 1);

    ch_state_t        state;
    ch_state_t        state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [CNT_W-1:0] load_val;
    logic             at_last;

    // Value loaded on any accepted trigger; len is only looked at here, so a
    // running pulse is immune to later len changes unless it is retriggered.
    assign load_val = (len == '0) ? DEF_LOAD : (len - CNT_ONE);

    // cnt==0 in ACTIVE marks the final high cycle of the current pulse.
    assign at_last = (cnt == '0);

    always_comb begin
        // NOTE: every variable driven here gets a default before the case,
        // so no path can leave it unassigned and infer a latch.
        state_nxt = state;
        cnt_nxt   = cnt;
        unique case (state)
            ST_IDLE: begin
                if (en) begin
                    state_nxt = ST_ACTIVE;
                    cnt_nxt   = load_val;
                end
            end
            ST_ACTIVE: begin
                // One-shot mode still accepts a trigger on the last cycle,
                // which chains the next pulse with no low gap.
                if (en && (retrig || at_last)) begin
                    cnt_nxt = load_val;
                end else if (at_last) begin
                    state_nxt = ST_IDLE;
                end else begin
                    cnt_nxt = cnt - CNT_ONE;
                end
            end
        endcase
    end

    assign active_nxt = (state_nxt == ST_ACTIVE);

    always_ff @(posedge clk or negedge rstn) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples the pre-edge values regardless of statement order.
        if (!rstn) begin
            state <= ST_IDLE;
            cnt   <= '0;
            dout  <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            dout  <= active_nxt;
        end
    end

`ifdef PULSE_STRETCH_DONE_EN
    // Registered on the ACTIVE->IDLE transition, so it lines up with the
    // first low cycle of dout. Chained one-shot pulses never leave ACTIVE
    // and therefore only strobe once, after the last pulse.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            done <= 1'b0;
        end else begin
            done <= (state == ST_ACTIVE) && (state_nxt == ST_IDLE);
        end
    end
`endif

endmodule : pulse_stretch_ch

// File: rtl/pulse_stretch_mc.sv
// -----------------------------------------------------------------------------
// pulse_stretch_mc
//
// Multi-channel pulse stretcher. CH independent pulse_stretch_ch instances
// share len and retrig; each stretches its own en bit into dout. busy is a
// registered OR of all channels, aligned with dout (low in the first cycle
// after the last pulse ends).
//
// Optional feature (macro PULSE_STRETCH_DONE_EN): adds output done[CH-1:0],
// a one-cycle per-channel strobe in the first cycle dout[i] is low after a
// pulse ends. Without the macro the port and its logic do not exist.
//
// Ports:
//   clk     in   rising-edge clock
//   rstn    in   asynchronous active-low reset
//   en      in   [CH-1:0]    per-channel trigger
//   len     in   [CNT_W-1:0] pulse length, 0 selects LEN_DEF
//   retrig  in   1 = retriggerable, 0 = one-shot
//   dout    out  [CH-1:0]    stretched pulses, registered
//   busy    out  registered OR of dout
//   done    out  [CH-1:0]    end-of-pulse strobes (PULSE_STRETCH_DONE_EN only)
// -----------------------------------------------------------------------------
module pulse_stretch_mc
    import pulse_stretch_pkg::*;
#(
    parameter int CH      = CH_DEFAULT,
    parameter int CNT_W   = CNT_W_DEFAULT,
    parameter int LEN_DEF = LEN_DEF_DEFAULT
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [CH-1:0]    en,
    input  logic [CNT_W-1:0] len,
    input  logic             retrig,
    output logic [CH-1:0]    dout,
    output logic             busy
`ifdef PULSE_STRETCH_DONE_EN
    ,
    output logic [CH-1:0]    done
`endif
);

    logic [CH-1:0] active_nxt;

    for (genvar i = 0; i < CH; i++) begin : g_ch
        pulse_stretch_ch #(
            .CNT_W   (CNT_W),
            .LEN_DEF (LEN_DEF)
        ) u_ch (
            .clk        (clk),
            .rstn       (rstn),
            .en         (en[i]),
            .len        (len),
            .retrig     (retrig),
            .dout       (dout[i]),
            .active_nxt (active_nxt[i])
`ifdef PULSE_STRETCH_DONE_EN
            ,
            .done       (done[i])
`endif
        );
    end

    // Built from the channels' next-state flags rather than from dout, so
    // busy is a true register yet carries no extra cycle of lag.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            busy <= 1'b0;
        end else begin
            busy <= |active_nxt;
        end
    end

endmodule : pulse_stretch_mc

// File: tb/tb_pulse_stretch_mc.sv
// -----------------------------------------------------------------------------
// tb_pulse_stretch_mc
//
// Self-checking bench for pulse_stretch_mc. Each step drives inputs on the
// falling edge, advances a remaining-cycles reference model and queues the
// expected dout/busy/done; a monitor pops and compares 1 time unit after
// the following rising edge. Scenario tasks additionally check pulse lengths
// and positions against hand-derived constants. Define PULSE_STRETCH_DONE_EN
// to also cover the done output.
// -----------------------------------------------------------------------------
module tb_pulse_stretch_mc;

    localparam int CH      = 4;
    localparam int CNT_W   = 5;
    localparam int LEN_DEF = 10;

    logic             clk;
    logic             rstn;
    logic [CH-1:0]    en;
    logic [CNT_W-1:0] len;
    logic             retrig;
    logic [CH-1:0]    dout;
    logic             busy;
`ifdef PULSE_STRETCH_DONE_EN
    logic [CH-1:0]    done;
`endif

    typedef struct packed {
        logic [CH-1:0] dout;
        logic          busy;
        logic [CH-1:0] done;
    } exp_t;

    exp_t          sb_q[$];
    exp_t          mon_x;
    int            rem[CH];       // model: high cycles still to come per channel
    int            checks = 0;
    int            errors = 0;
    logic [CH-1:0] obs_dout;
    logic          obs_busy;
`ifdef PULSE_STRETCH_DONE_EN
    logic [CH-1:0] obs_done;
`endif

    pulse_stretch_mc #(
        .CH      (CH),
        .CNT_W   (CNT_W),
        .LEN_DEF (LEN_DEF)
    ) dut (
        .clk    (clk),
        .rstn   (rstn),
        .en     (en),
        .len    (len),
        .retrig (retrig),
        .dout   (dout),
        .busy   (busy)
`ifdef PULSE_STRETCH_DONE_EN
        ,
        .done   (done)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard drain: one expected entry per driven step.
    always @(posedge clk) begin
        #1;
        if (sb_q.size() > 0) begin
            mon_x = sb_q.pop_front();
            checks++;
            if (dout !== mon_x.dout) begin
                errors++;
                $display("FAIL sb_dout t=%0t got %b expected %b", $time, dout, mon_x.dout);
            end
            checks++;
            if (busy !== mon_x.busy) begin
                errors++;
                $display("FAIL sb_busy t=%0t got %b expected %b", $time, busy, mon_x.busy);
            end
`ifdef PULSE_STRETCH_DONE_EN
            checks++;
            if (done !== mon_x.done) begin
                errors++;
                $display("FAIL sb_done t=%0t got %b expected %b", $time, done, mon_x.done);
            end
`endif
        end
    end

    task automatic model_clear();
        for (int i = 0; i < CH; i++) rem[i] = 0;
    endtask

    // One clock of stimulus; afterwards obs_* hold the post-edge outputs.
    task automatic step(input logic [CH-1:0] e, input logic [CNT_W-1:0] l, input logic r);
        exp_t x;
        int   eff;
        int   old;
        @(negedge clk);
        en     = e;
        len    = l;
        retrig = r;
        eff    = (l == '0) ? LEN_DEF : int'(l);
        for (int i = 0; i < CH; i++) begin
            old = rem[i];
            if (old == 0)                    rem[i] = e[i] ? eff : 0;
            else if (e[i] && (r || old == 1)) rem[i] = eff;
            else                             rem[i] = old - 1;
            x.dout[i] = (rem[i] > 0);
            x.done[i] = (old > 0) && (rem[i] == 0);
        end
        x.busy = |x.dout;
        sb_q.push_back(x);
        @(posedge clk);
        #2;
        obs_dout = dout;
        obs_busy = busy;
`ifdef PULSE_STRETCH_DONE_EN
        obs_done = done;
`endif
    endtask

    // Drives channel ch from bit pattern pat (bit k = en at step k) for n
    // steps and reports how many cycles dout[ch] was high and where.
    task automatic run_pattern(input int ch, input logic [31:0] pat, input int n,
                               input logic [CNT_W-1:0] l, input logic r,
                               output int cnt, output int first, output int last);
        logic [CH-1:0] e;
        cnt   = 0;
        first = -1;
        last  = -1;
        for (int k = 0; k < n; k++) begin
            e     = '0;
            e[ch] = pat[k];
            step(e, l, r);
            if (obs_dout[ch]) begin
                cnt++;
                if (first < 0) first = k;
                last = k;
            end
        end
    endtask

    task automatic test_reset();
        rstn   = 1'b0;
        en     = '0;
        len    = '0;
        retrig = 1'b0;
        model_clear();
        repeat (3) @(posedge clk);
        #2;
        checks++;
        if (dout !== '0) begin errors++; $display("FAIL reset_dout got %b expected 0", dout); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b expected 0", busy); end
`ifdef PULSE_STRETCH_DONE_EN
        checks++;
        if (done !== '0) begin errors++; $display("FAIL reset_done got %b expected 0", done); end
`endif
        @(negedge clk);
        rstn = 1'b1;
    endtask

    task automatic test_single_shot();
        int hi = 0;
        int other = 0;
        step(4'b0001, 5'd10, 1'b0);
        checks++;
        if (obs_dout[0] !== 1'b1) begin
            errors++; $display("FAIL single_first_cycle got %b expected 1", obs_dout[0]);
        end
        hi = int'(obs_dout[0]);
        for (int k = 0; k < 12; k++) begin
            step('0, 5'd10, 1'b0);
            hi    += int'(obs_dout[0]);
            other += (obs_dout[3:1] != '0) ? 1 : 0;
        end
        checks++;
        if (hi != 10) begin errors++; $display("FAIL single_len got %0d expected 10", hi); end
        checks++;
        if (other != 0) begin errors++; $display("FAIL single_others got %0d expected 0", other); end
    endtask

    task automatic test_len_default();
        int c, f, l;
        run_pattern(1, 32'h1, 13, 5'd0, 1'b0, c, f, l);
        checks++;
        if (c != 10) begin errors++; $display("FAIL len0_default got %0d expected 10", c); end
        run_pattern(1, 32'h1, 3, 5'd1, 1'b0, c, f, l);
        checks++;
        if (c != 1 || f != 0) begin
            errors++; $display("FAIL len1 got cnt %0d first %0d expected 1 0", c, f);
        end
    endtask

    task automatic test_retrig();
        int c, f, l;
        run_pattern(2, 32'b1001, 10, 5'd4, 1'b1, c, f, l);
        checks++;
        if (c != 7 || f != 0 || l != 6) begin
            errors++; $display("FAIL retrig_extend got %0d/%0d/%0d expected 7/0/6", c, f, l);
        end
    endtask

    task automatic test_oneshot();
        int c, f, l;
        run_pattern(2, 32'b1001, 8, 5'd4, 1'b0, c, f, l);
        checks++;
        if (c != 4 || f != 0 || l != 3) begin
            errors++; $display("FAIL oneshot_ignore got %0d/%0d/%0d expected 4/0/3", c, f, l);
        end
        run_pattern(2, 32'b10001, 11, 5'd4, 1'b0, c, f, l);
        checks++;
        if (c != 8 || f != 0 || l != 7) begin
            errors++; $display("FAIL oneshot_chain got %0d/%0d/%0d expected 8/0/7", c, f, l);
        end
    endtask

    task automatic test_back_to_back();
        int c, f, l;
        // one-shot, en held 9 cycles, len 3: pulses start at 0,3,6 with no gap
        run_pattern(3, 32'h1FF, 13, 5'd3, 1'b0, c, f, l);
        checks++;
        if (c != 9 || f != 0 || l != 8) begin
            errors++; $display("FAIL b2b_oneshot got %0d/%0d/%0d expected 9/0/8", c, f, l);
        end
        // retriggerable, en held 5 cycles, len 3: high until 3 cycles past last en
        run_pattern(3, 32'h1F, 12, 5'd3, 1'b1, c, f, l);
        checks++;
        if (c != 7 || f != 0 || l != 6) begin
            errors++; $display("FAIL b2b_retrig got %0d/%0d/%0d expected 7/0/6", c, f, l);
        end
    endtask

    task automatic test_len_latch();
        int hi;
        step(4'b0010, 5'd5, 1'b0);
        hi = int'(obs_dout[1]);
        for (int k = 0; k < 7; k++) begin
            step('0, 5'd2, 1'b0);
            hi += int'(obs_dout[1]);
        end
        checks++;
        if (hi != 5) begin errors++; $display("FAIL len_latched got %0d expected 5", hi); end
        // a retrigger resamples len: 5 at step 0, retrigger with 2 at step 2
        step(4'b0010, 5'd5, 1'b1);
        hi = int'(obs_dout[1]);
        step('0, 5'd5, 1'b1);
        hi += int'(obs_dout[1]);
        step(4'b0010, 5'd2, 1'b1);
        hi += int'(obs_dout[1]);
        for (int k = 0; k < 6; k++) begin
            step('0, 5'd2, 1'b1);
            hi += int'(obs_dout[1]);
        end
        checks++;
        if (hi != 4) begin errors++; $display("FAIL len_resample got %0d expected 4", hi); end
    endtask

    task automatic test_retrig_switch();
        int hi = 0;
        int last = -1;
        logic [CH-1:0] e;
        logic          r;
        for (int k = 0; k < 12; k++) begin
            e = (k == 0 || k == 2 || k == 3) ? 4'b0001 : 4'b0000;
            r = (k == 3);
            step(e, 5'd6, r);
            if (obs_dout[0]) begin hi++; last = k; end
        end
        checks++;
        if (hi != 9 || last != 8) begin
            errors++; $display("FAIL retrig_switch got %0d/%0d expected 9/8", hi, last);
        end
    endtask

    task automatic test_multi();
        int hi[CH];
        for (int i = 0; i < CH; i++) hi[i] = 0;
        for (int k = 0; k < 8; k++) begin
            step((k == 0) ? 4'b1111 : 4'b0000, 5'd6, 1'b0);
            for (int i = 0; i < CH; i++) hi[i] += int'(obs_dout[i]);
            if (k == 5) begin
                checks++;
                if (obs_busy !== 1'b1) begin errors++; $display("FAIL multi_busy_high got %b expected 1", obs_busy); end
            end
            if (k == 6) begin
                checks++;
                if (obs_busy !== 1'b0) begin errors++; $display("FAIL multi_busy_low got %b expected 0", obs_busy); end
`ifdef PULSE_STRETCH_DONE_EN
                checks++;
                if (obs_done !== 4'b1111) begin errors++; $display("FAIL multi_done got %b expected 1111", obs_done); end
`endif
            end
        end
        for (int i = 0; i < CH; i++) begin
            checks++;
            if (hi[i] != 6) begin errors++; $display("FAIL multi_len ch%0d got %0d expected 6", i, hi[i]); end
        end
    endtask

    task automatic test_reset_mid();
        int hi;
        step(4'b0001, 5'd10, 1'b0);
        step('0, 5'd10, 1'b0);
        step('0, 5'd10, 1'b0);
        @(negedge clk);
        rstn = 1'b0;
        model_clear();
        #1;
        checks++;
        if (dout !== '0) begin errors++; $display("FAIL rst_mid_dout got %b expected 0", dout); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy got %b expected 0", busy); end
        @(posedge clk);
        #2;
        checks++;
        if (dout !== '0) begin errors++; $display("FAIL rst_hold_dout got %b expected 0", dout); end
        @(negedge clk);
        rstn = 1'b1;
        step(4'b0001, 5'd10, 1'b0);
        hi = int'(obs_dout[0]);
        for (int k = 0; k < 11; k++) begin
            step('0, 5'd10, 1'b0);
            hi += int'(obs_dout[0]);
        end
        checks++;
        if (hi != 10) begin errors++; $display("FAIL rst_retrigger got %0d expected 10", hi); end
    endtask

    task automatic test_random();
        logic [CH-1:0]    e;
        logic [CNT_W-1:0] l;
        logic             r = 1'b0;
        for (int k = 0; k < 300; k++) begin
            for (int i = 0; i < CH; i++) e[i] = ($urandom_range(0, 3) == 0);
            l = CNT_W'($urandom_range(0, 6));
            if ($urandom_range(0, 7) == 0) r = ~r;
            step(e, l, r);
        end
        for (int k = 0; k < 12; k++) step('0, 5'd0, r);
    endtask

    initial begin
        test_reset();
        test_single_shot();
        test_len_default();
        test_retrig();
        test_oneshot();
        test_back_to_back();
        test_len_latch();
        test_retrig_switch();
        test_multi();
        test_reset_mid();
        test_random();
        @(posedge clk);
        #3;
        checks++;
        if (sb_q.size() != 0) begin
            errors++; $display("FAIL sb_drain got %0d pending expected 0", sb_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_pulse_stretch_mc
